tile_addr_gen: RTL and testbench



---
 rtl/tile_addr_gen_if.sv | 38 +++
 rtl/tile_addr_gen.sv | 155 +++++++++++++++
 tb/tb_tile_addr_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/tile_addr_gen_if.sv
// Scan-position in / tile-address out bundle for tile_addr_gen.
// master = scan timing side, slave = the address generator.
interface tile_addr_gen_if #(
    parameter int COL_W     = 10,
    parameter int ROW_W     = 9,
    parameter int TILE_LOG2 = 6,
    parameter int GRID_LOG2 = 2
);
    localparam int ADDR_W = 2 * TILE_LOG2;
    localparam int IDX_W  = 2 * GRID_LOG2;
    localparam int CNT_W  = 2 * (TILE_LOG2 + GRID_LOG2) + 1;

    logic              en;
    logic              pix_valid;
    logic              sof;
    logic [COL_W-1:0]  col_addr;
    logic [ROW_W-1:0]  row_addr;
    logic              out_valid;
    logic              out_sof;
    logic              out_in_board;
    logic              out_in_tile;
    logic              out_border;
    logic [IDX_W-1:0]  tile_idx;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  board_pix_cnt;

    modport master (
        output en, pix_valid, sof, col_addr, row_addr,
        input  out_valid, out_sof, out_in_board, out_in_tile, out_border,
               tile_idx, addr, board_pix_cnt
    );

    modport slave (
        input  en, pix_valid, sof, col_addr, row_addr,
        output out_valid, out_sof, out_in_board, out_in_tile, out_border,
               tile_idx, addr, board_pix_cnt
    );
endinterface

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: two-stage scan-position to board tile index / sprite address mapper.
// Per-tile border flags are built only when the TILE_BORDER_EN macro is defined.
module tile_addr_gen #(
    parameter int COL_W     = 10,
    parameter int ROW_W     = 9,
    parameter int ORIGIN_X  = 192,
    parameter int ORIGIN_Y  = 112,
    parameter int TILE_LOG2 = 6,
    parameter int GRID_LOG2 = 2,
    parameter int BORDER_W  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    tile_addr_gen_if.slave bus
);
    localparam int          ADDR_W = 2 * TILE_LOG2;
    localparam int          IDX_W  = 2 * GRID_LOG2;
    localparam int          PIX_W  = TILE_LOG2 + GRID_LOG2;
    localparam int unsigned BOARD  = 1 << PIX_W;
    localparam int          CNT_W  = 2 * PIX_W + 1;
    localparam int          DXW    = COL_W + 1;
    localparam int          DYW    = ROW_W + 1;

    localparam logic signed [DXW-1:0] ORG_X = DXW'(ORIGIN_X);
    localparam logic signed [DYW-1:0] ORG_Y = DYW'(ORIGIN_Y);

    // The board must fit the scan coordinate range and the border must fit in a tile.
    if (PIX_W > COL_W || PIX_W > ROW_W || 2 * BORDER_W > (1 << TILE_LOG2)) begin : g_param_check
        $error("tile_addr_gen: board or border does not fit the configured widths");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic signed [DXW-1:0] dx_c;
    logic signed [DYW-1:0] dy_c;
    logic                  inside_c;

    // Sign bit rejects positions left of / above the origin before the size compare.
    assign dx_c     = $signed({1'b0, bus.col_addr}) - ORG_X;
    assign dy_c     = $signed({1'b0, bus.row_addr}) - ORG_Y;
    assign inside_c = bus.pix_valid && !dx_c[COL_W] && !dy_c[ROW_W]
                   && (32'(dx_c[COL_W-1:0]) < BOARD)
                   && (32'(dy_c[ROW_W-1:0]) < BOARD);

    // ---- stage 1: board-relative offsets and inside flag ----
    logic             vld_p1;
    logic             sof_p1;
    logic             inside_p1;
    logic [PIX_W-1:0] dx_p1;
    logic [PIX_W-1:0] dy_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            sof_p1    <= 1'b0;
            inside_p1 <= 1'b0;
            dx_p1     <= '0;
            dy_p1     <= '0;
        end else if (bus.en) begin
            vld_p1    <= bus.pix_valid;
            sof_p1    <= bus.sof;
            inside_p1 <= inside_c;
            dx_p1     <= dx_c[PIX_W-1:0];
            dy_p1     <= dy_c[PIX_W-1:0];
        end
    end

    logic [GRID_LOG2-1:0] tx_p1;
    logic [GRID_LOG2-1:0] ty_p1;
    logic [TILE_LOG2-1:0] lx_p1;
    logic [TILE_LOG2-1:0] ly_p1;

    assign tx_p1 = dx_p1[TILE_LOG2 +: GRID_LOG2];
    assign ty_p1 = dy_p1[TILE_LOG2 +: GRID_LOG2];
    assign lx_p1 = dx_p1[TILE_LOG2-1:0];
    assign ly_p1 = dy_p1[TILE_LOG2-1:0];

    // ---- stage 2: tile index, sprite address, flags ----
    logic              vld_p2;
    logic              sof_p2;
    logic              in_board_p2;
    logic [IDX_W-1:0]  tile_idx_p2;
    logic [ADDR_W-1:0] addr_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2      <= 1'b0;
            sof_p2      <= 1'b0;
            in_board_p2 <= 1'b0;
            tile_idx_p2 <= '0;
            addr_p2     <= '0;
        end else if (bus.en) begin
            vld_p2      <= vld_p1;
            sof_p2      <= sof_p1;
            in_board_p2 <= inside_p1;
            tile_idx_p2 <= inside_p1 ? {ty_p1, tx_p1} : '0;
            addr_p2     <= inside_p1 ? {ly_p1, lx_p1} : '0;
        end
    end

`ifdef TILE_BORDER_EN
    localparam logic [TILE_LOG2-1:0] BW_LO = TILE_LOG2'(BORDER_W);
    localparam logic [TILE_LOG2-1:0] BW_HI = TILE_LOG2'((1 << TILE_LOG2) - BORDER_W);

    logic border_c;
    logic border_p2;
    logic in_tile_p2;

    assign border_c = inside_p1 && (lx_p1 < BW_LO || ly_p1 < BW_LO ||
                                    lx_p1 >= BW_HI || ly_p1 >= BW_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            border_p2  <= 1'b0;
            in_tile_p2 <= 1'b0;
        end else if (bus.en) begin
            border_p2  <= border_c;
            in_tile_p2 <= inside_p1 && !border_c;
        end
    end

    assign bus.out_border  = border_p2;
    assign bus.out_in_tile = in_tile_p2;
`else
    assign bus.out_border  = 1'b0;
    assign bus.out_in_tile = in_board_p2;
`endif

    // ---- stage 2: per-frame in-board pixel count, latched when sof leaves the pipe ----
    logic [CNT_W-1:0] cnt_p2;
    logic [CNT_W-1:0] board_cnt_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p2       <= '0;
            board_cnt_p2 <= '0;
        end else if (bus.en) begin
            if (sof_p1) begin
                board_cnt_p2 <= inside_p1 ? sat_inc(cnt_p2) : cnt_p2;
                cnt_p2       <= CNT_W'(inside_p1);
            end else if (inside_p1) begin
                cnt_p2 <= sat_inc(cnt_p2);
            end
        end
    end

    assign bus.out_valid     = vld_p2;
    assign bus.out_sof       = sof_p2;
    assign bus.out_in_board  = in_board_p2;
    assign bus.tile_idx      = tile_idx_p2;
    assign bus.addr          = addr_p2;
    assign bus.board_pix_cnt = board_cnt_p2;
endmodule

// File: tb/tb_tile_addr_gen.sv
// Scoreboard bench for tile_addr_gen: driver pushes reference-model results, monitor pops on each advance.
module tb_tile_addr_gen;
    localparam int COL_W     = 10;
    localparam int ROW_W     = 9;
    localparam int ORIGIN_X  = 192;
    localparam int ORIGIN_Y  = 112;
    localparam int TILE_LOG2 = 6;
    localparam int GRID_LOG2 = 2;
    localparam int BORDER_W  = 2;
    localparam int ADDR_W    = 2 * TILE_LOG2;
    localparam int IDX_W     = 2 * GRID_LOG2;
    localparam int CNT_W     = 2 * (TILE_LOG2 + GRID_LOG2) + 1;
    localparam int TILE      = 1 << TILE_LOG2;
    localparam int GRID      = 1 << GRID_LOG2;
    localparam int BOARD     = TILE * GRID;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_addr_gen_if #(.COL_W(COL_W), .ROW_W(ROW_W), .TILE_LOG2(TILE_LOG2), .GRID_LOG2(GRID_LOG2)) bus ();

    tile_addr_gen #(
        .COL_W(COL_W), .ROW_W(ROW_W), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y),
        .TILE_LOG2(TILE_LOG2), .GRID_LOG2(GRID_LOG2), .BORDER_W(BORDER_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic              valid;
        logic              sof;
        logic              in_board;
        logic              in_tile;
        logic              border;
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  bcnt;
    } out_t;

    out_t q[$];
    out_t last_exp = '0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mcnt     = 0;
    int   mboard   = 0;

    function automatic out_t sample();
        out_t s;
        s.valid    = bus.out_valid;
        s.sof      = bus.out_sof;
        s.in_board = bus.out_in_board;
        s.in_tile  = bus.out_in_tile;
        s.border   = bus.out_border;
        s.idx      = bus.tile_idx;
        s.addr     = bus.addr;
        s.bcnt     = bus.board_pix_cnt;
        return s;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s t=%0t: got v=%0d sof=%0d inb=%0d intile=%0d brd=%0d idx=%0d addr=%0d cnt=%0d, want v=%0d sof=%0d inb=%0d intile=%0d brd=%0d idx=%0d addr=%0d cnt=%0d",
                         name, $time, act.valid, act.sof, act.in_board, act.in_tile, act.border,
                         act.idx, act.addr, act.bcnt, exp.valid, exp.sof, exp.in_board,
                         exp.in_tile, exp.border, exp.idx, exp.addr, exp.bcnt);
        end
    endtask

    // Reference: board geometry with plain integer arithmetic, frame count as a running tally.
    function automatic out_t model(input bit pv, input bit sf, input int col, input int row);
        out_t e = '0;
        int dx = col - ORIGIN_X;
        int dy = row - ORIGIN_Y;
        bit ins = pv && dx >= 0 && dy >= 0 && dx < BOARD && dy < BOARD;
        e.valid    = pv;
        e.sof      = sf;
        e.in_board = ins;
        if (ins) begin
            int lx = dx % TILE;
            int ly = dy % TILE;
            e.idx  = IDX_W'((dy / TILE) * GRID + dx / TILE);
            e.addr = ADDR_W'(ly * TILE + lx);
`ifdef TILE_BORDER_EN
            e.border = (lx < BORDER_W) || (ly < BORDER_W) || (lx >= TILE - BORDER_W) || (ly >= TILE - BORDER_W);
`endif
            e.in_tile = !e.border;
        end
        if (sf) begin
            mboard = (mcnt + int'(ins) > CMAX) ? CMAX : mcnt + int'(ins);
            mcnt   = int'(ins);
        end else if (ins) begin
            mcnt = (mcnt + 1 > CMAX) ? CMAX : mcnt + 1;
        end
        e.bcnt = CNT_W'(mboard);
        return e;
    endfunction

    task automatic drive(input bit en, input bit pv, input bit sf, input int col, input int row);
        @(negedge clk);
        bus.en        = en;
        bus.pix_valid = pv;
        bus.sof       = sf;
        bus.col_addr  = COL_W'(col);
        bus.row_addr  = ROW_W'(row);
        if (en) q.push_back(model(pv, sf, col, row));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.col_addr  = '0;
        bus.row_addr  = '0;
        q.delete();
        mcnt     = 0;
        mboard   = 0;
        last_exp = '0;
        #1;
        check("async_reset", sample(), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: each advancing edge retires the item presented one advance earlier;
    // a stalled edge must leave the outputs where they were.
    initial begin
        bit adv;
        bit rs;
        forever begin
            @(posedge clk);
            adv = bus.en;
            rs  = rst_n;
            #1;
            if (rs && rst_n) begin
                if (adv && q.size() >= 2) last_exp = q.pop_front();
                check(adv ? "advance" : "stall", sample(), last_exp);
            end
        end
    end

    initial begin
        out_t want_cnt;
        bus.en = 1'b0; bus.pix_valid = 1'b0; bus.sof = 1'b0;
        bus.col_addr = '0; bus.row_addr = '0;
        do_reset();

        // origin, interior, far corner
        drive(1, 1, 0, 192, 112);
        drive(1, 1, 0, 325, 311);
        drive(1, 1, 0, 447, 367);
        // just outside each edge, and not-valid on the origin
        drive(1, 1, 0, 191, 112);
        drive(1, 1, 0, 448, 112);
        drive(1, 1, 0, 200, 368);
        drive(1, 0, 0, 192, 112);

        // stream with a 3-cycle stall in the middle; stalled positions must be dropped
        drive(1, 1, 0, 200, 120);
        drive(1, 1, 0, 201, 121);
        drive(0, 1, 1, 300, 200);
        drive(0, 1, 0, 301, 201);
        drive(0, 1, 0, 302, 202);
        drive(1, 1, 0, 202, 122);
        drive(1, 1, 0, 203, 123);
        drive(1, 1, 0, 204, 124);

        // border probes
        drive(1, 1, 0, 192, 112);
        drive(1, 1, 0, 194, 114);
        drive(1, 1, 0, 255, 150);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // randomized positions biased toward the board edges, random stalls and sof
        for (int i = 0; i < 1500; i++) begin
            bit en = ($urandom_range(0, 3) != 0);
            bit pv = ($urandom_range(0, 7) != 0);
            bit sf = ($urandom_range(0, 99) == 0);
            int col = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                                  : ORIGIN_X - 2 + int'($urandom_range(0, BOARD + 3));
            int row = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511))
                                                  : ORIGIN_Y - 2 + int'($urandom_range(0, BOARD + 3));
            drive(en, pv, sf, col, row);
        end

        // one frame: sof at (0,0), every board pixel, a few outside pixels, then next sof
        drive(1, 1, 1, 0, 0);
        for (int r = 0; r < BOARD; r++)
            for (int c = 0; c < BOARD; c++)
                drive(1, 1, 0, ORIGIN_X + c, ORIGIN_Y + r);
        drive(1, 1, 0, 639, 479);
        drive(1, 1, 0, 100, 400);
        drive(1, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        want_cnt      = sample();
        want_cnt.bcnt = CNT_W'(65536);
        check("frame_count", sample(), want_cnt);

        // part of the next frame, then reset mid-frame
        for (int c = 0; c < 10; c++) drive(1, 1, 0, ORIGIN_X + c, ORIGIN_Y);
        do_reset();
        for (int c = 0; c < 4; c++) drive(1, 1, 0, ORIGIN_X + c, ORIGIN_Y + 5);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
